mgpio_axil: RTL and testbench
=============================

# mgpio_axil

AXI4-Lite GPIO controller, the parametrised successor to the single-byte GPIO slave. It serves `BANKS` banks of `DW` pins each and has independent, buffered AW/W/AR channels with byte strobes. Per-pin rising/falling edge detection feeds a W1C status register and a single level interrupt. It sits on the peripheral AXI4-Lite interconnect and drives the pad ring directly.

## Interface
- `BANKS`, 1: number of GPIO banks.
- `DW`, 32: bus data width and pins per bank; legal values 8, 16, 32.
- `BANKS_WIDTH`, `BANKS>1 ? $clog2(BANKS) : 1`: width of the bank index.
- `AB`, `$clog2(DW/8)`: byte-offset bits within one register.
- `ADDR_W`, `AB+3+BANKS_WIDTH`: address width.
- Ports, in order:
  - `clk` in 1: single clock.
  - `rst_n` in 1: reset, asynchronous, active-low.
  - `awaddr` in ADDR_W, `awprot` in 3 (ignored), `awvalid` in 1, `awready` out 1.
  - `wdata` in DW, `wstrb` in DW/8, `wvalid` in 1, `wready` out 1.
  - `bresp` out 2, `bvalid` out 1, `bready` in 1.
  - `araddr` in ADDR_W, `arprot` in 3 (ignored), `arvalid` in 1, `arready` out 1.
  - `rdata` out DW, `rresp` out 2, `rvalid` out 1, `rready` in 1.
  - `gpio_in` in BANKS*DW: asynchronous pad inputs.
  - `gpio_out` out BANKS*DW; `gpio_oe` out BANKS*DW.
  - `irq` out 1: level interrupt.

## Operation
- Address decode:
  - Register index `ri = addr[AB+2:AB]`; bank `bk = addr[AB+3 +: BANKS_WIDTH]`; low `AB` bits are ignored.
  - Bank stride is 8 registers.
- Registers per bank (ri: name):
  - 0 `IN`: read-only, synchronised pins.
  - 1 `OUT`, 2 `OE`, 3 `IE`, 4 `RISE_EN`, 5 `FALL_EN`: read/write.
  - 6 `STATUS`: write-1-to-clear.
  - 7 `RSVD`: reads 0, writes ignored, OKAY.
- Writes:
  - Byte lanes are masked by `wstrb`.
  - For `STATUS`, only strobed bytes clear.
  - Write to `IN` is ignored and returns OKAY.
- Error: `bk >= BANKS` returns SLVERR (2'b10), reads return `rdata=0`, and no state changes. All other accesses return OKAY (2'b00).
- Input path: 2-FF synchroniser per pin, followed by a `prev` register.
  - `rise = sync & ~prev`; `fall = ~sync & prev`.
  - `STATUS <= (STATUS & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)`. A set wins over a W1C clear in the same cycle.
- `irq` is registered: `irq <= |(STATUS & IE)` over all banks.
- `gpio_out = OUT` and `gpio_oe = OE`, driven directly from the registers.
- Write channel:
  - One-entry AW buffer and one-entry W buffer; AW and W may arrive in any order or cycle.
  - `awready = ~aw_full & rdy`; `wready = ~w_full & rdy`.
  - Commit happens when `aw_full & w_full & ~bvalid`: the register is updated, `bvalid` is set, and both buffers clear on the same edge.
  - `bvalid` holds until `bready`.
- Read channel:
  - `arready = ~rvalid & rdy`.
  - On AR handshake, `rdata`/`rresp` are registered and `rvalid` is set; all are held stable until `rready`.
- `rdy` is a flop cleared by reset and set on the first edge after `rst_n` rises.

## Timing
- Reset (async assert, sync release via `rdy`):
  - All registers, synchronisers, buffers, `bvalid`, `rvalid`, `irq`, `gpio_out`, `gpio_oe`, `rdata`, `bresp`, `rresp` are 0.
  - All readies are 0 until one cycle after release.
- Write latency:
  - AW and W accepted on the same edge E0 → register updated and `bvalid=1` at E1.
  - If `bvalid` is pending, the buffers stay full and `awready`/`wready` stay 0 until the B handshake completes; commit then occurs on the following edge.
- Read latency: AR handshake at E0 → `rvalid=1` with data at E0. Reads reflect register state before any commit on the same edge, so a read racing a write to the same register returns the old value.
- Read and write channels are fully independent; both may handshake on the same edge.
- Input latency:
  - Pin change before edge k → visible in `IN` after edge k+1.
  - STATUS bit set after edge k+2; `irq` high after edge k+3.
- Reset mid-transaction: all in-flight AW, W and AR transactions are discarded; no response is issued.

## Test plan
- Reset release: `awready`/`wready`/`arready` low for one cycle, then high. With DW=32, BANKS=2, write `OUT` bank1 = 0xA5A5A5A5 with `wstrb=4'b0011` → `gpio_out[63:32]=0x0000A5A5`, `bresp=OKAY`, `bvalid` one cycle after the handshake.
- W presented 3 cycles before AW → no commit until AW accepted; single B response. With `bready` held low, a second AW/W pair is back-pressured (`awready=0` after buffering) until B completes.
- Set `RISE_EN=0x1`, `IE=0x1`, toggle `gpio_in[0]` 0→1 → `STATUS=0x1` after 3 edges, `irq=1` after 4. A W1C of 0x1 → `irq` drops. A W1C coincident with a new rising edge → STATUS stays 1.
- Read `araddr` with `bk=3` when BANKS=2 → `rresp=2'b10`, `rdata=0`. Write to the same address → `bresp=2'b10` and no register changes.
- Read and write of `OE` handshaking on the same edge → `rdata` returns the old value; a subsequent read returns the new value. With `rready` held low for 5 cycles, `rdata` is stable and `arready=0`.
- Assert `rst_n` low with W buffered and `rvalid` high → all outputs return to 0 immediately; no B or R response after release.

Source files
------------

// File: rtl/mgpio_axil_if.sv
`default_nettype none
// ============================================================================
// Module      : mgpio_axil_if
// Description : AXI4-Lite bus bundle for the mgpio_axil GPIO controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mgpio_axil_if #(
    parameter int DW     = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/mgpio_axil.sv
`default_nettype none
// ============================================================================
// Module      : mgpio_axil
// Description : AXI4-Lite GPIO controller, BANKS x DW pins, edge-detect W1C
//               status and a single level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module mgpio_axil #(
    parameter int BANKS       = 1,
    parameter int DW          = 32,
    parameter int BANKS_WIDTH = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int AB          = $clog2(DW / 8),
    parameter int ADDR_W      = AB + 3 + BANKS_WIDTH
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    mgpio_axil_if.slave              bus,
    input  wire logic [BANKS*DW-1:0] gpio_in,
    output logic      [BANKS*DW-1:0] gpio_out,
    output logic      [BANKS*DW-1:0] gpio_oe,
    output logic                     irq
);

    localparam int                   c_nb     = DW / 8;
    localparam int                   c_vw     = BANKS * DW;
    localparam logic [BANKS_WIDTH:0] c_banks  = (BANKS_WIDTH + 1)'(BANKS);
    localparam logic [1:0]           c_okay   = 2'b00;
    localparam logic [1:0]           c_slverr = 2'b10;

    logic                   r_rdy;
    logic                   r_aw_full;
    logic                   r_w_full;
    logic [ADDR_W-1:0]      r_aw_addr;
    logic [DW-1:0]          r_w_data;
    logic [c_nb-1:0]        r_w_strb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [DW-1:0]          r_rdata;
    logic                   r_irq;

    logic [c_vw-1:0]        r_sync1;
    logic [c_vw-1:0]        r_sync2;
    logic [c_vw-1:0]        r_prev;
    logic [c_vw-1:0]        r_out;
    logic [c_vw-1:0]        r_oe;
    logic [c_vw-1:0]        r_ie;
    logic [c_vw-1:0]        r_rise_en;
    logic [c_vw-1:0]        r_fall_en;
    logic [c_vw-1:0]        r_status;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic                   w_wen;
    logic [2:0]             w_wr_ri;
    logic [BANKS_WIDTH-1:0] w_wr_bk;
    logic                   w_wr_ok;
    logic [2:0]             w_rd_ri;
    logic [BANKS_WIDTH-1:0] w_rd_bk;
    logic                   w_rd_ok;
    logic [DW-1:0]          w_wmask;
    logic [DW-1:0]          w_rd_word;
    logic [c_vw-1:0]        w_clr;
    logic [c_vw-1:0]        w_rise;
    logic [c_vw-1:0]        w_fall;
    logic                   w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [DW-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign bus.awready = ~r_aw_full & r_rdy;
    assign bus.wready  = ~r_w_full & r_rdy;
    assign bus.arready = ~r_rvalid & r_rdy;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.rvalid  = r_rvalid;
    assign bus.rresp   = r_rresp;
    assign bus.rdata   = r_rdata;

    assign gpio_out = r_out;
    assign gpio_oe  = r_oe;
    assign irq      = r_irq;

    assign w_aw_hs  = bus.awvalid & bus.awready;
    assign w_w_hs   = bus.wvalid & bus.wready;
    assign w_ar_hs  = bus.arvalid & bus.arready;
    assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

    assign w_wr_ri = r_aw_addr[AB+2:AB];
    assign w_wr_bk = r_aw_addr[AB+3 +: BANKS_WIDTH];
    assign w_wr_ok = ({1'b0, w_wr_bk} < c_banks);
    assign w_wen   = w_commit & w_wr_ok;

    assign w_rd_ri = bus.araddr[AB+2:AB];
    assign w_rd_bk = bus.araddr[AB+3 +: BANKS_WIDTH];
    assign w_rd_ok = ({1'b0, w_rd_bk} < c_banks);

    // Protection bits and the byte-offset address bits carry no meaning here.
    assign w_unused = &{1'b0, bus.awprot, bus.arprot, r_aw_addr, bus.araddr};

    for (genvar i = 0; i < c_nb; i++) begin : g_wmask
        assign w_wmask[i*8 +: 8] = {8{r_w_strb[i]}};
    end

    assign w_rise = r_sync2 & ~r_prev & r_rise_en;
    assign w_fall = ~r_sync2 & r_prev & r_fall_en;

    always_comb begin
        w_clr = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_wen && (w_wr_ri == 3'd6) && (w_wr_bk == BANKS_WIDTH'(b))) begin
                w_clr[b*DW +: DW] = r_w_data & w_wmask;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_rd_ok && (w_rd_bk == BANKS_WIDTH'(b))) begin
                case (w_rd_ri)
                    3'd0:    w_rd_word = r_sync2[b*DW +: DW];
                    3'd1:    w_rd_word = r_out[b*DW +: DW];
                    3'd2:    w_rd_word = r_oe[b*DW +: DW];
                    3'd3:    w_rd_word = r_ie[b*DW +: DW];
                    3'd4:    w_rd_word = r_rise_en[b*DW +: DW];
                    3'd5:    w_rd_word = r_fall_en[b*DW +: DW];
                    3'd6:    w_rd_word = r_status[b*DW +: DW];
                    default: w_rd_word = '0;
                endcase
            end
        end
    end

    // Input synchroniser, edge history, status and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy    <= 1'b0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_rdy    <= 1'b1;
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_status <= (r_status & ~w_clr) | w_rise | w_fall;
            r_irq    <= |(r_status & r_ie);
        end
    end

    // Write channel: independent one-entry AW and W buffers, commit when both held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= bus.awaddr;
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= bus.wdata;
                r_w_strb <= bus.wstrb;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
            if (r_bvalid && bus.bready) begin
                r_bvalid <= 1'b0;
            end else if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_okay : c_slverr;
            end
        end
    end

    // Read channel samples registers before any same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_okay;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_ok ? c_okay : c_slverr;
                r_rdata  <= w_rd_word;
            end else if (r_rvalid && bus.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_ie      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (w_wen && (w_wr_bk == BANKS_WIDTH'(b))) begin
                    case (w_wr_ri)
                        3'd1: r_out[b*DW +: DW] <=
                            f_merge(r_out[b*DW +: DW], r_w_data, w_wmask);
                        3'd2: r_oe[b*DW +: DW] <=
                            f_merge(r_oe[b*DW +: DW], r_w_data, w_wmask);
                        3'd3: r_ie[b*DW +: DW] <=
                            f_merge(r_ie[b*DW +: DW], r_w_data, w_wmask);
                        3'd4: r_rise_en[b*DW +: DW] <=
                            f_merge(r_rise_en[b*DW +: DW], r_w_data, w_wmask);
                        3'd5: r_fall_en[b*DW +: DW] <=
                            f_merge(r_fall_en[b*DW +: DW], r_w_data, w_wmask);
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mgpio_axil.sv
`default_nettype none
// ============================================================================
// Module      : tb_mgpio_axil
// Description : Directed scoreboard bench for mgpio_axil (BANKS=3, DW=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mgpio_axil;

    localparam int BANKS  = 3;
    localparam int DW     = 32;
    localparam int ADDR_W = 7;
    localparam int VW     = BANKS * DW;

    logic          clk;
    logic          rst_n;
    logic [VW-1:0] gpio_in;
    logic [VW-1:0] gpio_out;
    logic [VW-1:0] gpio_oe;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    mgpio_axil_if #(.DW(DW), .ADDR_W(ADDR_W)) bus ();

    mgpio_axil #(.BANKS(BANKS), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_b(input string tag);
        logic [1:0] e;
        e = exp_b.pop_front();
        chk({tag, "_bresp"}, bus.bresp, e);
    endtask

    task automatic pop_r(input string tag);
        logic [33:0] e;
        e = exp_r.pop_front();
        chk({tag, "_rdata"}, bus.rdata, e[31:0]);
        chk({tag, "_rresp"}, bus.rresp, e[33:32]);
    endtask

    task automatic wait_b(input string tag, output int lat);
        lat = 0;
        while (!bus.bvalid && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_bvalid"}, bus.bvalid, 1'b1);
        pop_b(tag);
        if (bus.bready) tick();
    endtask

    task automatic wr(input string tag, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] er, output int lat);
        bit awd, wd, ah, wh;
        int t;
        exp_b.push_back(er);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        awd = 0; wd = 0; t = 0;
        while (!(awd && wd) && t < 50) begin
            ah = bus.awvalid & bus.awready;
            wh = bus.wvalid & bus.wready;
            tick();
            t++;
            if (ah) begin awd = 1; bus.awvalid = 1'b0; end
            if (wh) begin wd = 1; bus.wvalid = 1'b0; end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk({tag, "_accept"}, {awd, wd}, 2'b11);
        wait_b(tag, lat);
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] ed,
                      input logic [1:0] er);
        bit h, done;
        int t;
        exp_r.push_back({er, ed});
        bus.araddr = a; bus.arvalid = 1'b1;
        done = 0; t = 0;
        while (!done && t < 50) begin
            h = bus.arready;
            tick();
            t++;
            if (h) done = 1;
        end
        bus.arvalid = 1'b0;
        chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
        pop_r(tag);
        if (bus.rready) tick();
    endtask

    initial begin
        int  lat;
        bit  h;
        rst_n = 1'b0;
        gpio_in = '0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        // Reset state and ready release
        repeat (3) tick();
        chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst_gpio_out", gpio_out, '0);
        chk("rst_gpio_oe", gpio_oe, '0);
        chk("rst_valids_irq", {bus.bvalid, bus.rvalid, irq}, 3'b000);
        chk("rst_rdata", bus.rdata, '0);
        rst_n = 1'b1;
        chk("rel_readies_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        chk("rel_readies_high", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Strobed write to OUT of bank 1
        wr("out1", 7'h24, 32'hA5A5A5A5, 4'b0011, 2'b00, lat);
        chk("out1_latency", lat, 1);
        chk("out1_gpio", gpio_out, 96'h00000000_0000A5A5_00000000);
        rd("out1_rd", 7'h24, 32'h0000A5A5, 2'b00);
        wr("out2", 7'h44, 32'h12345678, 4'b1100, 2'b00, lat);
        chk("out2_gpio", gpio_out, 96'h12340000_0000A5A5_00000000);

        // W three cycles ahead of AW, then back-pressure behind a pending B
        bus.wdata = 32'h000000FF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        h = bus.wready;
        tick();
        bus.wvalid = 1'b0;
        chk("wearly_wready", h, 1'b1);
        repeat (3) begin
            tick();
            chk("wearly_no_commit", bus.bvalid, 1'b0);
        end
        chk("wearly_oe_idle", gpio_oe, '0);
        exp_b.push_back(2'b00);
        bus.bready = 1'b0;
        bus.awaddr = 7'h08; bus.awvalid = 1'b1;
        chk("wearly_awready", bus.awready, 1'b1);
        tick();
        bus.awvalid = 1'b0;
        tick();
        chk("wearly_bvalid", bus.bvalid, 1'b1);
        pop_b("wearly");
        chk("wearly_oe", gpio_oe, 96'h000000FF);
        exp_b.push_back(2'b00);
        bus.awaddr = 7'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'h00000F00; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (3) begin
            chk("bp_ready", {bus.awready, bus.wready}, 2'b00);
            chk("bp_oe_hold", gpio_oe, 96'h000000FF);
            tick();
        end
        bus.bready = 1'b1;
        tick();
        chk("bp_b1_done", bus.bvalid, 1'b0);
        tick();
        chk("bp_b2_valid", bus.bvalid, 1'b1);
        pop_b("bp2");
        chk("bp_oe_new", gpio_oe, 96'h00000F00);
        tick();
        chk("bp_b2_done", bus.bvalid, 1'b0);

        // Rising-edge status and interrupt timing
        wr("rise_en", 7'h10, 32'h1, 4'hF, 2'b00, lat);
        wr("ie", 7'h0C, 32'h1, 4'hF, 2'b00, lat);
        gpio_in[0] = 1'b1;
        repeat (3) begin
            tick();
            chk("irq_early", irq, 1'b0);
        end
        tick();
        chk("irq_set", irq, 1'b1);
        rd("status_set", 7'h18, 32'h1, 2'b00);
        rd("in_rd", 7'h00, 32'h1, 2'b00);
        wr("w1c", 7'h18, 32'h1, 4'hF, 2'b00, lat);
        chk("irq_cleared", irq, 1'b0);
        rd("status_clr", 7'h18, 32'h0, 2'b00);
        gpio_in[0] = 1'b0;
        repeat (4) tick();
        chk("fall_ignored", irq, 1'b0);
        gpio_in[0] = 1'b1;
        tick();
        exp_b.push_back(2'b00);
        bus.awaddr = 7'h18; bus.awvalid = 1'b1;
        bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        chk("race_w1c_bvalid", bus.bvalid, 1'b1);
        pop_b("race_w1c");
        tick();
        rd("set_wins", 7'h18, 32'h1, 2'b00);
        chk("set_wins_irq", irq, 1'b1);

        // Out-of-range bank, reserved register and IN writes
        rd("bad_rd", 7'h64, 32'h0, 2'b10);
        wr("bad_wr", 7'h64, 32'hFFFFFFFF, 4'hF, 2'b10, lat);
        chk("bad_wr_out", gpio_out, 96'h12340000_0000A5A5_00000000);
        chk("bad_wr_oe", gpio_oe, 96'h00000F00);
        rd("rsvd_rd", 7'h1C, 32'h0, 2'b00);
        wr("in_wr", 7'h00, 32'h0, 4'hF, 2'b00, lat);
        rd("in_after_wr", 7'h00, 32'h1, 2'b00);

        // Same-edge read and write of OE with rready held low
        bus.rready = 1'b0;
        exp_r.push_back({2'b00, 32'h00000F00});
        exp_b.push_back(2'b00);
        bus.awaddr = 7'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'h00001234; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 7'h08; bus.arvalid = 1'b1;
        chk("same_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("same_rvalid", bus.rvalid, 1'b1);
        pop_r("same_old");
        tick();
        chk("same_bvalid", bus.bvalid, 1'b1);
        pop_b("same");
        repeat (5) begin
            chk("hold_rdata", bus.rdata, 32'h00000F00);
            chk("hold_arready", {bus.arready, bus.rvalid}, 2'b01);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        chk("hold_released", bus.rvalid, 1'b0);
        rd("same_new", 7'h08, 32'h00001234, 2'b00);

        // Reset with a buffered W and a pending R
        bus.wdata = 32'h0000DEAD; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
        bus.araddr = 7'h24; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("pre_rst_state", {bus.rvalid, irq}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gpio", {gpio_out, gpio_oe}, '0);
        chk("mid_rst_flags", {bus.bvalid, bus.rvalid, irq}, 3'b000);
        chk("mid_rst_rdata", bus.rdata, '0);
        tick();
        rst_n = 1'b1;
        bus.rready = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_quiet", {bus.bvalid, bus.rvalid}, 2'b00);
        end
        exp_b.push_back(2'b00);
        bus.awaddr = 7'h04; bus.awvalid = 1'b1;
        h = bus.awready;
        tick();
        bus.awvalid = 1'b0;
        chk("post_rst_awready", h, 1'b1);
        repeat (3) begin
            tick();
            chk("w_discarded", bus.bvalid, 1'b0);
        end
        bus.wdata = 32'h00000055; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick();
        chk("post_rst_bvalid", bus.bvalid, 1'b1);
        pop_b("post_rst");
        chk("post_rst_out", gpio_out, 96'h00000000_00000000_00000055);
        tick();

        chk("sb_empty", exp_b.size() + exp_r.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
